// File: rtl/command_status_responder_pkg.sv
// Shared command/status protocol types.
// Used by the responder, its bus interface and the bridges.
package command_status_responder_pkg;

  typedef enum logic {
    CMD_WRITE = 1'b0,
    CMD_READ  = 1'b1
  } cmd_e;

  typedef enum logic {
    STS_OK    = 1'b0,
    STS_ERROR = 1'b1
  } status_e;

  function automatic int unsigned timer_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/command_status_responder_if.sv
// Combined command/status bus.
// Master issues commands and takes status; slave does the reverse.
interface command_status_responder_if;
  import command_status_responder_pkg::*;

  logic    command_valid;
  logic    command_ready;
  cmd_e    command;
  logic    status_valid;
  logic    status_ready;
  status_e status;

  modport master (
    output command_valid,
    output command,
    input  command_ready,
    input  status_valid,
    input  status,
    output status_ready
  );

  modport slave (
    input  command_valid,
    input  command,
    output command_ready,
    output status_valid,
    output status,
    input  status_ready
  );

endinterface

// File: rtl/command_status_responder_latency_timer.sv
// Load/decrement service-latency counter.
// done is high whenever the count sits at zero.
module command_status_responder_latency_timer #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_q;

  // Load wins over decrement; decrement stops at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/command_status_responder.sv
// Slave endpoint: accepts WRITE/READ, tracks occupancy,
// returns one OK/ERROR status per command after LATENCY.
module command_status_responder
  import command_status_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  command_status_responder_if.slave bus,
  output logic [CW-1:0] o_count
);

  localparam int unsigned TW = timer_width(LATENCY);
  localparam logic [TW-1:0] LOAD_VAL = TW'(LATENCY - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q;
  status_e       status_q;
  logic          accept;
  logic          t_load;
  logic          t_dec;
  logic          t_done;
  logic          wr_ok, wr_err, rd_ok, rd_err;

  command_status_responder_latency_timer #(
    .W (TW)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .load     (t_load),
    .load_val (LOAD_VAL),
    .dec      (t_dec),
    .done     (t_done)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and timer control.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.command_valid && bus.command_ready) begin
          accept  = 1'b1;
          t_load  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (t_done) state_d = RESPOND;
        else        t_dec   = 1'b1;
      end
      RESPOND: begin
        if (bus.status_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ok  = (bus.command == CMD_WRITE) && (count_q != FULL);
  assign wr_err = (bus.command == CMD_WRITE) && (count_q == FULL);
  assign rd_ok  = (bus.command == CMD_READ)  && (count_q != '0);
  assign rd_err = (bus.command == CMD_READ)  && (count_q == '0);

  // Occupancy and latched status, both updated at acceptance.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q  <= '0;
      status_q <= STS_OK;
    end else if (accept) begin
      unique case (1'b1)
        wr_ok: begin
          count_q  <= count_q + 1'b1;
          status_q <= STS_OK;
        end
        rd_ok: begin
          count_q  <= count_q - 1'b1;
          status_q <= STS_OK;
        end
        wr_err, rd_err: begin
          status_q <= STS_ERROR;
        end
        default: status_q <= STS_ERROR;
      endcase
    end
  end

  assign bus.command_ready = (state_q == IDLE) && !i_rst;
  assign bus.status_valid  = (state_q == RESPOND);
  assign bus.status        = status_q;
  assign o_count           = count_q;

endmodule

// File: tb/tb_command_status_responder.sv
// Directed bench for command_status_responder.
// Two instances: LATENCY=2 and LATENCY=1, both DEPTH=4.
module tb_command_status_responder;
  import command_status_responder_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [2:0] cnt1;
  logic [2:0] cnt2;
  int         checks = 0;
  int         errors = 0;

  command_status_responder_if bus1 ();
  command_status_responder_if bus2 ();

  command_status_responder #(
    .DEPTH   (4),
    .LATENCY (2)
  ) dut1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .bus     (bus1.slave),
    .o_count (cnt1)
  );

  command_status_responder #(
    .DEPTH   (4),
    .LATENCY (1)
  ) dut2 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .bus     (bus2.slave),
    .o_count (cnt2)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // One full command on dut1 with status_ready held high.
  task automatic do_cmd(input string tag, input cmd_e c,
                        input status_e es, input int ec);
    bus1.command       = c;
    bus1.command_valid = 1'b1;
    bus1.status_ready  = 1'b1;
    step();
    bus1.command_valid = 1'b0;
    check({tag, "_cnt"}, 32'(cnt1), 32'(ec));
    check({tag, "_rdy_busy"}, 32'(bus1.command_ready), 0);
    check({tag, "_vld_t1"}, 32'(bus1.status_valid), 0);
    step();
    check({tag, "_vld_t1b"}, 32'(bus1.status_valid), 0);
    step();
    check({tag, "_vld_t2"}, 32'(bus1.status_valid), 1);
    check({tag, "_sts"}, 32'(bus1.status), 32'(es));
    step();
    check({tag, "_vld_hs"}, 32'(bus1.status_valid), 0);
    check({tag, "_rdy_hs"}, 32'(bus1.command_ready), 1);
  endtask

  cmd_e    seq_c [6];
  status_e seq_s [6];

  initial begin
    int idx;
    int nstat;
    logic acc;
    logic sv;
    status_e st;

    bus1.command_valid = 1'b0;
    bus1.command       = CMD_WRITE;
    bus1.status_ready  = 1'b0;
    bus2.command_valid = 1'b0;
    bus2.command       = CMD_WRITE;
    bus2.status_ready  = 1'b1;

    // Reset state.
    step();
    step();
    check("rst_rdy", 32'(bus1.command_ready), 0);
    check("rst_vld", 32'(bus1.status_valid), 0);
    check("rst_cnt", 32'(cnt1), 0);
    check("rst_sts", 32'(bus1.status), 32'(STS_OK));
    i_rst = 1'b0;
    #1;
    check("rel_rdy", 32'(bus1.command_ready), 1);

    // Underflow right after reset, then fill past DEPTH and drain.
    do_cmd("rd0", CMD_READ, STS_ERROR, 0);
    do_cmd("wr1", CMD_WRITE, STS_OK, 1);
    do_cmd("wr2", CMD_WRITE, STS_OK, 2);
    do_cmd("wr3", CMD_WRITE, STS_OK, 3);
    do_cmd("wr4", CMD_WRITE, STS_OK, 4);
    do_cmd("wr5", CMD_WRITE, STS_ERROR, 4);
    do_cmd("rd3", CMD_READ, STS_OK, 3);
    do_cmd("rd2", CMD_READ, STS_OK, 2);
    do_cmd("rd1", CMD_READ, STS_OK, 1);
    do_cmd("rd0b", CMD_READ, STS_OK, 0);
    do_cmd("rd_un", CMD_READ, STS_ERROR, 0);

    // Backpressure in RESPOND with a stray command pulse.
    bus1.status_ready  = 1'b0;
    bus1.command       = CMD_WRITE;
    bus1.command_valid = 1'b1;
    step();
    bus1.command_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      check("hold_vld", 32'(bus1.status_valid), 1);
      check("hold_sts", 32'(bus1.status), 32'(STS_OK));
      check("hold_rdy", 32'(bus1.command_ready), 0);
      if (i == 4) begin
        bus1.command       = CMD_READ;
        bus1.command_valid = 1'b1;
      end else begin
        bus1.command_valid = 1'b0;
      end
      step();
    end
    bus1.command_valid = 1'b0;
    check("hold_cnt", 32'(cnt1), 1);
    bus1.status_ready = 1'b1;
    step();
    check("hold_hs_vld", 32'(bus1.status_valid), 0);
    check("hold_hs_rdy", 32'(bus1.command_ready), 1);
    check("hold_hs_cnt", 32'(cnt1), 1);

    // Asynchronous reset while BUSY.
    bus1.command       = CMD_WRITE;
    bus1.command_valid = 1'b1;
    step();
    bus1.command_valid = 1'b0;
    check("mid_cnt", 32'(cnt1), 2);
    #2;
    i_rst = 1'b1;
    #1;
    check("mid_rst_vld", 32'(bus1.status_valid), 0);
    check("mid_rst_rdy", 32'(bus1.command_ready), 0);
    check("mid_rst_cnt", 32'(cnt1), 0);
    step();
    i_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_vld", 32'(bus1.status_valid), 0);
    end
    check("post_rst_cnt", 32'(cnt1), 0);
    check("post_rst_rdy", 32'(bus1.command_ready), 1);

    // LATENCY=1 back-to-back stream on dut2.
    seq_c = '{CMD_WRITE, CMD_WRITE, CMD_READ,
              CMD_READ, CMD_READ, CMD_WRITE};
    seq_s = '{STS_OK, STS_OK, STS_OK,
              STS_OK, STS_ERROR, STS_OK};
    idx   = 0;
    nstat = 0;
    bus2.command       = seq_c[0];
    bus2.command_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && nstat < 6; cyc++) begin
      acc = bus2.command_ready && bus2.command_valid;
      sv  = bus2.status_valid && bus2.status_ready;
      st  = bus2.status;
      step();
      if (acc) idx++;
      if (sv) begin
        check("l1_sts", 32'(st), 32'(seq_s[nstat]));
        nstat++;
      end
      bus2.command_valid = (idx < 6);
      if (idx < 6) bus2.command = seq_c[idx];
    end
    bus2.command_valid = 1'b0;
    check("l1_nstat", 32'(nstat), 6);
    check("l1_cnt", 32'(cnt2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
